// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared FSM states, register indices and CTRL/STATUS bit positions for dma_controller
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR0  = 3'd4,
    S_WR1  = 3'd5
  } state_t;

  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN_LO = 3'd4;
  localparam logic [2:0] REG_LEN_HI = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_START     = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_SRC_FIXED = 2;
  localparam int CTRL_DST_FIXED = 3;
  localparam int CTRL_ABORT     = 4;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;

endpackage

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - single-channel memory-to-memory DMA engine with CPU register slave and bus master
import dma_pkg::*;

module dma_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rwb,
  output logic [7:0]  dma_data_out,
  input  logic [7:0]  dma_data_in,
  output logic        irq
);

  state_t      state, state_nxt;
  logic [15:0] src, dst, len;
  logic [7:0]  hold;
  logic        irq_en, src_fixed, dst_fixed, done, aborted, abort_pend;
  logic        set_done, set_aborted, clear_flags;

  logic        wr, busy, ctrl_wr, stat_wr, start_req, abort_req, last_xfer;
  logic [15:0] len_dec;

  assign wr        = cs & ~rw;
  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = wr && (addr == REG_CTRL);
  assign stat_wr   = wr && (addr == REG_STATUS);
  assign start_req = ctrl_wr && data_in[CTRL_START] && !busy;
  // An abort written this cycle counts at once, so REQ can bail out without an extra cycle
  assign abort_req = busy && (abort_pend || (ctrl_wr && data_in[CTRL_ABORT]));
  assign last_xfer = (state == S_WR1) && bus_gnt;
  assign len_dec   = len - 16'd1;
  assign irq       = irq_en & (done | aborted);

  // Next-state selection and bus master outputs
  always_comb begin
    state_nxt    = state;
    set_done     = 1'b0;
    set_aborted  = 1'b0;
    clear_flags  = 1'b0;
    bus_req      = busy;
    dma_active   = 1'b0;
    dma_rwb      = 1'b1;
    dma_addr     = 16'h0000;
    dma_data_out = 8'h00;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          if (len == 16'd0) begin
            set_done = 1'b1;
          end else begin
            state_nxt   = S_REQ;
            clear_flags = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (abort_req) begin
          state_nxt   = S_IDLE;
          set_aborted = 1'b1;
        end else if (bus_gnt) begin
          state_nxt = S_RD0;
        end
      end
      S_RD0: if (bus_gnt) state_nxt = S_RD1;
      S_RD1: if (bus_gnt) state_nxt = S_WR0;
      S_WR0: if (bus_gnt) state_nxt = S_WR1;
      S_WR1: begin
        if (bus_gnt) begin
          if (abort_req) begin
            state_nxt   = S_IDLE;
            set_aborted = 1'b1;
          end else if (len_dec == 16'd0) begin
            state_nxt = S_IDLE;
            set_done  = 1'b1;
          end else begin
            state_nxt = S_RD0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Master outputs are only live while the bus is actually ours
    if (bus_gnt && (state == S_RD0 || state == S_RD1)) begin
      dma_active = 1'b1;
      dma_addr   = src;
    end else if (bus_gnt && (state == S_WR0 || state == S_WR1)) begin
      dma_active   = 1'b1;
      dma_rwb      = 1'b0;
      dma_addr     = dst;
      dma_data_out = hold;
    end
  end

  // State, register file, counters and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      src        <= 16'h0000;
      dst        <= 16'h0000;
      len        <= 16'h0000;
      hold       <= 8'h00;
      irq_en     <= 1'b0;
      src_fixed  <= 1'b0;
      dst_fixed  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr && !busy) begin
        case (addr)
          REG_SRC_LO: src[7:0]  <= data_in;
          REG_SRC_HI: src[15:8] <= data_in;
          REG_DST_LO: dst[7:0]  <= data_in;
          REG_DST_HI: dst[15:8] <= data_in;
          REG_LEN_LO: len[7:0]  <= data_in;
          REG_LEN_HI: len[15:8] <= data_in;
          default: ;
        endcase
      end
      if (ctrl_wr && !busy) begin
        irq_en    <= data_in[CTRL_IRQ_EN];
        src_fixed <= data_in[CTRL_SRC_FIXED];
        dst_fixed <= data_in[CTRL_DST_FIXED];
      end
      if (state_nxt == S_IDLE) abort_pend <= 1'b0;
      else if (busy && ctrl_wr && data_in[CTRL_ABORT]) abort_pend <= 1'b1;
      if (state == S_RD1 && bus_gnt) hold <= dma_data_in;
      if (last_xfer) begin
        len <= len_dec;
        if (!src_fixed) src <= src + 16'd1;
        if (!dst_fixed) dst <= dst + 16'd1;
      end
      // Later assignments win: a STATUS clear beats a same-cycle set
      if (set_done) done <= 1'b1;
      if (clear_flags || set_aborted) done <= 1'b0;
      if (stat_wr && data_in[ST_DONE]) done <= 1'b0;
      if (set_aborted) aborted <= 1'b1;
      if (clear_flags) aborted <= 1'b0;
      if (stat_wr && data_in[ST_ABORTED]) aborted <= 1'b0;
    end
  end

  // Register read mux; counters are always visible live
  always_comb begin
    data_out = 8'h00;
    case (addr)
      REG_SRC_LO: data_out = src[7:0];
      REG_SRC_HI: data_out = src[15:8];
      REG_DST_LO: data_out = dst[7:0];
      REG_DST_HI: data_out = dst[15:8];
      REG_LEN_LO: data_out = len[7:0];
      REG_LEN_HI: data_out = len[15:8];
      REG_CTRL:   data_out = {4'b0000, dst_fixed, src_fixed, irq_en, 1'b0};
      REG_STATUS: data_out = {5'b00000, aborted, done, busy};
      default:    data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - self-checking bench for dma_controller with a transfer-level reference model
module tb_dma_controller;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cs, rw, bus_gnt;
  logic [2:0]  addr;
  logic [7:0]  data_in, data_out;
  logic        bus_req, dma_active, dma_rwb, irq;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic [7:0]  dma_data_in = 8'h00;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] wr_log_a[$];
  logic [7:0]  wr_log_d[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  logic [7:0]  exp_final[int];
  logic [15:0] exp_src, exp_dst;
  int          active_cycles;
  bit          breq_seen;

  dma_controller dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_rwb(dma_rwb),
    .dma_data_out(dma_data_out), .dma_data_in(dma_data_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus responder and monitor: sampled mid-cycle, read data presented well before the capturing edge
  always @(negedge clk) begin
    if (bus_req === 1'b1) breq_seen = 1'b1;
    if (dma_active === 1'b1) begin
      active_cycles++;
      if (dma_rwb) begin
        rd_log.push_back(dma_addr);
        dma_data_in = mem[dma_addr];
      end else begin
        wr_log_a.push_back(dma_addr);
        wr_log_d.push_back(dma_data_out);
        mem[dma_addr] = dma_data_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    tick();
    cs = 1'b0; rw = 1'b1; data_in = 8'h00;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  task automatic read_regs(output logic [15:0] s, output logic [15:0] d, output logic [15:0] l);
    logic [7:0] lo, hi;
    rd_reg(REG_SRC_LO, lo); rd_reg(REG_SRC_HI, hi); s = {hi, lo};
    rd_reg(REG_DST_LO, lo); rd_reg(REG_DST_HI, hi); d = {hi, lo};
    rd_reg(REG_LEN_LO, lo); rd_reg(REG_LEN_HI, hi); l = {hi, lo};
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    wr_reg(REG_SRC_LO, s[7:0]); wr_reg(REG_SRC_HI, s[15:8]);
    wr_reg(REG_DST_LO, d[7:0]); wr_reg(REG_DST_HI, d[15:8]);
    wr_reg(REG_LEN_LO, l[7:0]); wr_reg(REG_LEN_HI, l[15:8]);
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete();
    active_cycles = 0;
    breq_seen = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (bus_req === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (bus_req === 1'b0);
  endtask

  // Transfer-level model: n byte copies, each seen on the bus as two read and two write beats
  task automatic model(input logic [15:0] s0, input logic [15:0] d0, input int n, input bit sf, input bit df);
    logic [15:0] s, d;
    logic [7:0]  b;
    s = s0; d = d0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_final.delete();
    for (int i = 0; i < n; i++) begin
      b = exp_final.exists(int'(s)) ? exp_final[int'(s)] : mem[s];
      repeat (2) begin
        exp_rd.push_back(s);
        exp_wa.push_back(d);
        exp_wd.push_back(b);
      end
      exp_final[int'(d)] = b;
      if (!sf) s = s + 16'd1;
      if (!df) d = d + 16'd1;
    end
    exp_src = s; exp_dst = d;
  endtask

  function automatic int log_errors();
    int e = 0;
    if (rd_log.size() != exp_rd.size() || wr_log_a.size() != exp_wa.size()) return 1000;
    foreach (exp_rd[i]) if (rd_log[i] !== exp_rd[i]) e++;
    foreach (exp_wa[i]) if (wr_log_a[i] !== exp_wa[i] || wr_log_d[i] !== exp_wd[i]) e++;
    foreach (exp_final[k]) if (mem[k] !== exp_final[k]) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; cs = 1'b0; rw = 1'b1; addr = 3'd0; data_in = 8'h00; bus_gnt = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if ({bus_req, dma_active, dma_rwb, dma_addr, dma_data_out, irq} !== {1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b act=%b rwb=%b addr=%h wdata=%h irq=%b, expected 0 0 1 0000 00 0",
               bus_req, dma_active, dma_rwb, dma_addr, dma_data_out, irq);
    end
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h expected 00", r, v);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] s, d, l;
    logic [7:0]  v;
    bit ok;
    int e;
    setup(16'h1000, 16'h2000, 16'd3);
    model(16'h1000, 16'h2000, 3, 1'b0, 1'b0);
    clear_logs();
    wr_reg(REG_CTRL, 8'h01);
    wr_reg(REG_SRC_LO, 8'h55);
    rd_reg(REG_CTRL, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL basic_ctrl_read: got %h expected 00", v); end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: bus_req=%b expected 0", bus_req); end
    total++;
    if (active_cycles != 12) begin bad++; $display("FAIL basic_active_cycles: got %0d expected 12", active_cycles); end
    e = log_errors();
    total++;
    if (e != 0) begin bad++; $display("FAIL basic_data: mismatches=%0d expected 0", e); end
    read_regs(s, d, l);
    total++;
    if ({s, d, l} !== {16'h1003, 16'h2003, 16'h0000}) begin
      bad++; $display("FAIL basic_regs: got src=%h dst=%h len=%h expected 1003 2003 0000", s, d, l);
    end
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h02) begin bad++; $display("FAIL basic_status: got %h expected 02", v); end
  endtask

  task automatic test_len_zero();
    logic [7:0] v;
    wr_reg(REG_STATUS, 8'h06);
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL lenzero_clear: got %h expected 00", v); end
    setup(16'h1234, 16'h4321, 16'd0);
    clear_logs();
    wr_reg(REG_CTRL, 8'h01);
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h02) begin bad++; $display("FAIL lenzero_done: got %h expected 02", v); end
    repeat (5) tick();
    total++;
    if (breq_seen || active_cycles != 0) begin
      bad++; $display("FAIL lenzero_no_bus: got req_seen=%b active=%0d expected 0 0", breq_seen, active_cycles);
    end
    wr_reg(REG_STATUS, 8'h00);
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h02) begin bad++; $display("FAIL status_write0: got %h expected 02", v); end
  endtask

  task automatic test_wrap();
    logic [15:0] s, d, l;
    bit ok;
    int e;
    setup(16'hFFFF, 16'h0300, 16'd2);
    model(16'hFFFF, 16'h0300, 2, 1'b0, 1'b1);
    clear_logs();
    wr_reg(REG_CTRL, 8'h09);
    wait_idle(100, ok);
    e = log_errors();
    total++;
    if (!ok || e != 0) begin bad++; $display("FAIL wrap_data: got done=%b mismatches=%0d expected 1 0", ok, e); end
    total++;
    if (rd_log.size() != 4 || rd_log[0] !== 16'hFFFF || rd_log[2] !== 16'h0000) begin
      bad++; $display("FAIL wrap_read_addr: got n=%0d expected reads FFFF then 0000", rd_log.size());
    end
    read_regs(s, d, l);
    total++;
    if ({s, d, l} !== {16'h0001, 16'h0300, 16'h0000}) begin
      bad++; $display("FAIL wrap_regs: got src=%h dst=%h len=%h expected 0001 0300 0000", s, d, l);
    end
    wr_reg(REG_CTRL, 8'h00);
  endtask

  task automatic test_gnt_drop();
    logic [15:0] s, d, l, saved;
    bit ok, found;
    int e, held_bad;
    setup(16'h4000, 16'h5000, 16'd2);
    model(16'h4000, 16'h5000, 2, 1'b0, 1'b0);
    clear_logs();
    wr_reg(REG_CTRL, 8'h01);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (dma_active === 1'b1 && dma_rwb === 1'b0) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin bad++; $display("FAIL gnt_find_wr0: got no write cycle expected one"); end
    saved = dma_addr;
    bus_gnt = 1'b0;
    held_bad = 0;
    repeat (5) begin
      #1;
      if (dma_active !== 1'b0 || dma_addr !== 16'h0 || dma_rwb !== 1'b1 || bus_req !== 1'b1) held_bad++;
      tick();
    end
    total++;
    if (held_bad != 0) begin bad++; $display("FAIL gnt_hold_outputs: got %0d bad cycles expected 0", held_bad); end
    bus_gnt = 1'b1;
    #1;
    total++;
    if (dma_active !== 1'b1 || dma_addr !== saved || dma_rwb !== 1'b0) begin
      bad++; $display("FAIL gnt_resume: got act=%b addr=%h rwb=%b expected 1 %h 0", dma_active, dma_addr, dma_rwb, saved);
    end
    wait_idle(100, ok);
    e = log_errors();
    read_regs(s, d, l);
    total++;
    if (!ok || e != 0 || active_cycles != 8 || {s, d, l} !== {16'h4002, 16'h5002, 16'h0000}) begin
      bad++; $display("FAIL gnt_complete: got idle=%b mism=%0d act=%0d src=%h dst=%h len=%h expected 1 0 8 4002 5002 0000",
                      ok, e, active_cycles, s, d, l);
    end
  endtask

  task automatic test_abort_irq();
    logic [15:0] s, d, l;
    logic [7:0]  v;
    bit ok;
    int rc, e;
    wr_reg(REG_STATUS, 8'h06);
    setup(16'h6000, 16'h7000, 16'd4);
    model(16'h6000, 16'h7000, 2, 1'b0, 1'b0);
    clear_logs();
    wr_reg(REG_CTRL, 8'h03);
    rc = 0;
    for (int n = 0; n < 60 && rc < 4; n++) begin
      tick();
      if (dma_active === 1'b1 && dma_rwb === 1'b1) rc++;
    end
    total++;
    if (rc != 4) begin bad++; $display("FAIL abort_find_rd1: got %0d read beats expected 4", rc); end
    wr_reg(REG_CTRL, 8'h12);
    wait_idle(100, ok);
    e = log_errors();
    read_regs(s, d, l);
    total++;
    if (!ok || e != 0 || {s, d, l} !== {16'h6002, 16'h7002, 16'h0002}) begin
      bad++; $display("FAIL abort_counters: got idle=%b mism=%0d src=%h dst=%h len=%h expected 1 0 6002 7002 0002",
                      ok, e, s, d, l);
    end
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h04 || irq !== 1'b1) begin bad++; $display("FAIL abort_status: got %h irq=%b expected 04 1", v, irq); end
    wr_reg(REG_STATUS, 8'h02);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL abort_irq_hold: got irq=%b expected 1", irq); end
    wr_reg(REG_STATUS, 8'h04);
    rd_reg(REG_STATUS, v);
    total++;
    if (v !== 8'h00 || irq !== 1'b0) begin bad++; $display("FAIL abort_irq_clear: got %h irq=%b expected 00 0", v, irq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    bit found;
    int nz;
    setup(16'h1100, 16'h2200, 16'd3);
    clear_logs();
    wr_reg(REG_CTRL, 8'h03);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (dma_active === 1'b1 && dma_rwb === 1'b0) found = 1'b1;
      else tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (!found || {bus_req, dma_active, dma_rwb, dma_addr, irq} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
      bad++; $display("FAIL rstmid_bus: got found=%b req=%b act=%b rwb=%b addr=%h irq=%b expected 1 0 0 1 0000 0",
                      found, bus_req, dma_active, dma_rwb, dma_addr, irq);
    end
    nz = 0;
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), v);
      if (v !== 8'h00) nz++;
    end
    total++;
    if (nz != 0) begin bad++; $display("FAIL rstmid_regs: got %0d nonzero registers expected 0", nz); end
    repeat (4) tick();
    total++;
    if (wr_log_a.size() != 1) begin bad++; $display("FAIL rstmid_no_wr1: got %0d write beats expected 1", wr_log_a.size()); end
  endtask

  task automatic test_random();
    logic [15:0] s0, d0, l0, s, d, l;
    logic [7:0]  v;
    bit sf, df;
    int e, n;
    for (int it = 0; it < 6; it++) begin
      s0 = 16'($urandom);
      d0 = s0 + 16'h8000;
      l0 = 16'($urandom_range(1, 6));
      sf = 1'($urandom);
      df = 1'($urandom);
      wr_reg(REG_STATUS, 8'h06);
      setup(s0, d0, l0);
      model(s0, d0, int'(l0), sf, df);
      clear_logs();
      wr_reg(REG_CTRL, {4'b0000, df, sf, 1'b0, 1'b1});
      n = 0;
      while (bus_req === 1'b1 && n < 400) begin
        bus_gnt = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      bus_gnt = 1'b1;
      e = log_errors();
      read_regs(s, d, l);
      rd_reg(REG_STATUS, v);
      total++;
      if (bus_req !== 1'b0 || e != 0 || {s, d, l} !== {exp_src, exp_dst, 16'h0000} || v !== 8'h02) begin
        bad++; $display("FAIL random_%0d: got req=%b mism=%0d src=%h dst=%h len=%h st=%h expected 0 0 %h %h 0000 02",
                        it, bus_req, e, s, d, l, v, exp_src, exp_dst);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_gnt_drop();
    test_abort_irq();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
